// File: rtl/sdf_pe.sv
// rtl/sdf_pe.sv - single-delay-feedback radix-2 butterfly stage with optional -j rotation
// Frame counter, feedback delay line and registered output; the pipeline only moves on accepted samples.
module sdf_pe #(
    parameter int WIDTH  = 12,
    parameter int DEPTH  = 16,
    parameter int ROT_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             sync,
    input  logic [WIDTH-1:0] data_in_re,
    input  logic [WIDTH-1:0] data_in_im,
    output logic             out_valid,
    output logic [WIDTH:0]   data_out_re,
    output logic [WIDTH:0]   data_out_im
);
    localparam int LD = $clog2(DEPTH);
    localparam int CW = LD + 2;
    localparam int OW = WIDTH + 1;

    logic [CW-1:0] r_cnt;
    logic          r_primed;
    logic [OW-1:0] r_dl_re [DEPTH];
    logic [OW-1:0] r_dl_im [DEPTH];
    logic          r_out_valid;
    logic [OW-1:0] r_out_re;
    logic [OW-1:0] r_out_im;

    logic [CW-1:0] w_cnt;
    logic          w_phase;
    logic          w_rot;
    logic          w_primed;
    logic [OW-1:0] w_x_re, w_x_im;
    logic [OW-1:0] w_a_re, w_a_im;
    logic [OW-1:0] w_wr_re, w_wr_im;
    logic [OW-1:0] w_res_re, w_res_im;

    // A sync sample is index 0 of a new frame and restarts the priming window.
    assign w_cnt    = sync ? '0 : r_cnt;
    assign w_phase  = w_cnt[LD];
    assign w_rot    = (ROT_EN != 0) && w_cnt[LD+1] && !w_phase;
    assign w_primed = r_primed & ~sync;

    assign w_x_re = {data_in_re[WIDTH-1], data_in_re};
    assign w_x_im = {data_in_im[WIDTH-1], data_in_im};
    assign w_a_re = r_dl_re[DEPTH-1];
    assign w_a_im = r_dl_im[DEPTH-1];

    always_comb begin
        w_wr_re  = w_x_re;
        w_wr_im  = w_x_im;
        w_res_re = w_a_re;
        w_res_im = w_a_im;
        if (w_phase) begin
            w_wr_re  = w_a_re - w_x_re;
            w_wr_im  = w_a_im - w_x_im;
            w_res_re = w_a_re + w_x_re;
            w_res_im = w_a_im + w_x_im;
        end else if (w_rot) begin
            // Stored differences never reach -2^WIDTH, so this negation is exact.
            w_res_re = w_a_im;
            w_res_im = -w_a_re;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_primed    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_dl_re[i] <= '0;
                r_dl_im[i] <= '0;
            end
        end else begin
            r_out_valid <= in_valid & w_primed;
            if (in_valid) begin
                r_cnt    <= w_cnt + {{(CW-1){1'b0}}, 1'b1};
                r_primed <= w_primed | (w_cnt == CW'(DEPTH - 1));
                r_out_re <= w_res_re;
                r_out_im <= w_res_im;
                r_dl_re[0] <= w_wr_re;
                r_dl_im[0] <= w_wr_im;
                for (int i = 1; i < DEPTH; i++) begin
                    r_dl_re[i] <= r_dl_re[i-1];
                    r_dl_im[i] <= r_dl_im[i-1];
                end
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign data_out_re = r_out_re;
    assign data_out_im = r_out_im;
endmodule
